// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - captures a pixel-clocked RGB444 + h/v sync stream into frame-buffer writes
module vga_capture #(
    parameter int          H_LINE       = 640,
    parameter int          H_BACK_PORCH = 48,
    parameter int          V_LINE       = 480,
    parameter int          V_BACK_PORCH = 33,
    parameter int          PIXEL_WIDTH  = H_LINE,
    parameter int          PIXEL_HEIGHT = V_LINE,
    parameter logic [47:0] PIXEL_FORMAT = "rgb332",
    parameter int          SYNC_ACTIVE  = 0,
    localparam int PIXEL_DEPTH = (PIXEL_FORMAT == 48'("rgb12")) ? 12 : 8,
    localparam int ADDR_W      = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT)
) (
    input  logic                   pxclk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [3:0]             r,
    input  logic [3:0]             g,
    input  logic [3:0]             b,
    input  logic                   hsync,
    input  logic                   vsync,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [PIXEL_DEPTH-1:0] wr_data,
    output logic                   capturing,
    output logic                   frame_done,
    output logic                   frame_err
);

    localparam int H_SCALE = H_LINE / PIXEL_WIDTH;
    localparam int V_SCALE = V_LINE / PIXEL_HEIGHT;
    localparam int XW      = $clog2(H_BACK_PORCH + H_LINE + 1);
    localparam int YW      = $clog2(V_BACK_PORCH + V_LINE + 1);
    localparam int HSW     = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
    localparam int VSW     = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;
    localparam int CW      = $clog2(PIXEL_WIDTH + 1);

    localparam logic [XW-1:0]     X_VIS     = XW'(H_BACK_PORCH);
    localparam logic [XW-1:0]     X_MAX     = XW'(H_BACK_PORCH + H_LINE);
    localparam logic [YW-1:0]     Y_VIS     = YW'(V_BACK_PORCH);
    localparam logic [YW-1:0]     Y_MAX     = YW'(V_BACK_PORCH + V_LINE);
    localparam logic [HSW-1:0]    HS_LAST   = HSW'(H_SCALE - 1);
    localparam logic [VSW-1:0]    VS_LAST   = VSW'(V_SCALE - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIXEL_WIDTH * PIXEL_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(PIXEL_WIDTH);
    localparam logic              SYNC_LVL  = (SYNC_ACTIVE != 0);

    if (!(PIXEL_FORMAT == 48'("rgb332") || PIXEL_FORMAT == 48'("rgb12"))) begin : g_bad_format
        $error("vga_capture: PIXEL_FORMAT must be \"rgb332\" or \"rgb12\"");
    end
    if (H_SCALE * PIXEL_WIDTH != H_LINE || V_SCALE * PIXEL_HEIGHT != V_LINE) begin : g_bad_scale
        $error("vga_capture: H_LINE/V_LINE must be integer multiples of PIXEL_WIDTH/PIXEL_HEIGHT");
    end

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_V_PORCH, S_ACTIVE, S_DONE} state_t;
    state_t state;

    logic [PIXEL_DEPTH-1:0] pix_in, pix_q;
    logic                   hs_q, vs_q, hs_act_d, vs_act_d;
    logic                   hs_act, vs_act, hs_edge, vs_edge;
    logic [XW-1:0]          x_cnt, x_now;
    logic [YW-1:0]          y_cnt, y_now;
    logic                   vs_pend;
    logic [HSW-1:0]         h_mod, h_mod_now;
    logic [VSW-1:0]         v_mod, v_mod_now;
    logic [CW-1:0]          col, col_now;
    logic [ADDR_W-1:0]      row_base, row_now, pix_addr;
    logic                   h_vis, v_vis, keep;

    // Packing happens before the input register so only the kept colour bits are stored.
    if (PIXEL_DEPTH == 12) begin : g_rgb12
        assign pix_in = {r, g, b};
    end else begin : g_rgb332
        logic unused_lsbs;
        assign pix_in      = {r[3:1], g[3:1], b[3:2]};
        assign unused_lsbs = ^{r[0], g[0], b[1:0]};
    end

    assign hs_act  = (hs_q == SYNC_LVL);
    assign vs_act  = (vs_q == SYNC_LVL);
    assign hs_edge = hs_act_d && !hs_act;
    assign vs_edge = vs_act_d && !vs_act;

    always_comb begin
        x_now = hs_edge ? '0 : x_cnt;
        y_now = y_cnt;
        if (hs_edge) begin
            if (vs_pend || vs_edge)
                y_now = '0;
            else if (y_cnt != Y_MAX)
                y_now = y_cnt + YW'(1);
        end else if (vs_edge) begin
            // Park y outside the window until the first line of the new frame.
            y_now = Y_MAX;
        end
        h_vis = (x_now >= X_VIS) && (x_now < X_MAX);
        v_vis = (y_now >= Y_VIS) && (y_now < Y_MAX);

        h_mod_now = h_mod;
        col_now   = col;
        if (x_now == X_VIS) begin
            h_mod_now = '0;
            col_now   = '0;
        end

        // Row bookkeeping advances on every line edge, so short lines cannot skew addresses.
        v_mod_now = v_mod;
        row_now   = row_base;
        if (hs_edge) begin
            if (y_now == Y_VIS) begin
                v_mod_now = '0;
                row_now   = '0;
            end else if (v_vis) begin
                if (v_mod == VS_LAST) begin
                    v_mod_now = '0;
                    row_now   = row_base + ROW_STEP;
                end else begin
                    v_mod_now = v_mod + VSW'(1);
                end
            end
        end

        keep     = h_vis && v_vis && (h_mod_now == '0) && (v_mod_now == '0) && !vs_edge;
        pix_addr = row_now + ADDR_W'(col_now);
    end

    always_ff @(posedge pxclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q    <= '0;
            hs_q     <= ~SYNC_LVL;
            vs_q     <= ~SYNC_LVL;
            hs_act_d <= 1'b0;
            vs_act_d <= 1'b0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            vs_pend  <= 1'b0;
            h_mod    <= '0;
            col      <= '0;
            v_mod    <= '0;
            row_base <= '0;
        end else begin
            pix_q    <= pix_in;
            hs_q     <= hsync;
            vs_q     <= vsync;
            hs_act_d <= hs_act;
            vs_act_d <= vs_act;
            x_cnt    <= (x_now == X_MAX) ? X_MAX : x_now + XW'(1);
            y_cnt    <= y_now;
            if (hs_edge)
                vs_pend <= 1'b0;
            else if (vs_edge)
                vs_pend <= 1'b1;
            h_mod <= h_mod_now;
            col   <= col_now;
            if (h_vis) begin
                if (h_mod_now == HS_LAST) begin
                    h_mod <= '0;
                    col   <= col_now + CW'(1);
                end else begin
                    h_mod <= h_mod_now + HSW'(1);
                end
            end
            v_mod    <= v_mod_now;
            row_base <= row_now;
        end
    end

    always_ff @(posedge pxclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            capturing  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (!enable) begin
                state     <= S_IDLE;
                capturing <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: state <= S_ARMED;
                    S_ARMED: begin
                        if (vs_edge) begin
                            state     <= S_V_PORCH;
                            capturing <= 1'b1;
                        end
                    end
                    S_V_PORCH, S_ACTIVE: begin
                        if (vs_edge) begin
                            frame_err <= 1'b1;
                            state     <= S_V_PORCH;
                        end else begin
                            if (state == S_V_PORCH && y_now == Y_VIS)
                                state <= S_ACTIVE;
                            if (keep) begin
                                wr_en   <= 1'b1;
                                wr_addr <= pix_addr;
                                wr_data <= pix_q;
                                if (pix_addr == ADDR_LAST) begin
                                    state     <= S_DONE;
                                    capturing <= 1'b0;
                                end
                            end
                        end
                    end
                    S_DONE: begin
                        frame_done <= 1'b1;
                        state      <= S_ARMED;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - directed bench for vga_capture on an 8x4 source with 2-pixel/1-line back porch
module tb_vga_capture;

    logic       pxclk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] r, g, b;
    logic       hsync, vsync;

    logic        wr_en, capturing, frame_done, frame_err;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en12, cap12, done12, err12;
    logic [4:0]  wr_addr12;
    logic [11:0] wr_data12;
    logic        wr_en_s, cap_s, done_s, err_s;
    logic [2:0]  wr_addr_s;
    logic [7:0]  wr_data_s;

    vga_capture #(.H_LINE(8), .H_BACK_PORCH(2), .V_LINE(4), .V_BACK_PORCH(1)) u_dut (
        .pxclk(pxclk), .rst_n(rst_n), .enable(enable), .r(r), .g(g), .b(b),
        .hsync(hsync), .vsync(vsync), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .capturing(capturing), .frame_done(frame_done), .frame_err(frame_err)
    );

    vga_capture #(.H_LINE(8), .H_BACK_PORCH(2), .V_LINE(4), .V_BACK_PORCH(1),
                  .PIXEL_FORMAT("rgb12")) u_dut12 (
        .pxclk(pxclk), .rst_n(rst_n), .enable(enable), .r(r), .g(g), .b(b),
        .hsync(hsync), .vsync(vsync), .wr_en(wr_en12), .wr_addr(wr_addr12), .wr_data(wr_data12),
        .capturing(cap12), .frame_done(done12), .frame_err(err12)
    );

    vga_capture #(.H_LINE(8), .H_BACK_PORCH(2), .V_LINE(4), .V_BACK_PORCH(1),
                  .PIXEL_WIDTH(4), .PIXEL_HEIGHT(2)) u_dut_s (
        .pxclk(pxclk), .rst_n(rst_n), .enable(enable), .r(r), .g(g), .b(b),
        .hsync(hsync), .vsync(vsync), .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
        .capturing(cap_s), .frame_done(done_s), .frame_err(err_s)
    );

    always #5 pxclk = ~pxclk;

    int cyc = 0;
    always @(posedge pxclk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    int la[512], ld[512], lc[512];
    int n_wr = 0, n_done = 0, n_ferr = 0, done_cyc = 0;
    int a12[512], d12[512];
    int n12 = 0;
    int as_[512], ds_[512];
    int ns = 0;

    always @(negedge pxclk) begin
        if (wr_en && n_wr < 512) begin
            la[n_wr] = int'(wr_addr);
            ld[n_wr] = int'(wr_data);
            lc[n_wr] = cyc;
        end
        if (wr_en) n_wr = n_wr + 1;
        if (frame_done) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
        end
        if (frame_err) n_ferr = n_ferr + 1;
        if (wr_en12 && n12 < 512) begin
            a12[n12] = int'(wr_addr12);
            d12[n12] = int'(wr_data12);
        end
        if (wr_en12) n12 = n12 + 1;
        if (wr_en_s && ns < 512) begin
            as_[ns] = int'(wr_addr_s);
            ds_[ns] = int'(wr_data_s);
        end
        if (wr_en_s) ns = ns + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] src(input int vl, input int cx);
        if (vl == 0 && cx == 0) return 12'hF85;
        return {4'(2 * vl), 4'(2 * cx), 4'hC};
    endfunction

    function automatic int pack332(input logic [11:0] p);
        logic [7:0] v;
        v = {p[11:9], p[7:5], p[3:2]};
        return int'(v);
    endfunction

    int first_px_cyc = 0;
    int drop_cyc = 0;

    // One 14-cycle line: 2 sync, 2 porch, 8 pixel slots, 2 front porch.
    task automatic do_line(input logic vs_lvl, input int npix, input int vl,
                           input int drop_at, input int rst_at);
        logic [11:0] p;
        for (int c = 0; c < 14; c++) begin
            @(posedge pxclk);
            #1;
            hsync = (c < 2) ? 1'b0 : 1'b1;
            vsync = vs_lvl;
            p = (c >= 4 && c < 4 + npix) ? src(vl, c - 4) : 12'h000;
            {r, g, b} = p;
            if (c == 4 && vl == 0 && npix > 0) first_px_cyc = cyc;
            if (c == drop_at) begin
                enable   = 1'b0;
                drop_cyc = cyc;
            end
            if (c == rst_at) begin
                #2;
                check("t6_pre_rst_wr_en", int'(wr_en), 1);
                check("t6_pre_rst_addr", int'(wr_addr), vl * 8 + rst_at - 6);
                rst_n = 1'b0;
                #1;
                check("t6_rst_wr_en", int'(wr_en), 0);
                check("t6_rst_capturing", int'(capturing), 0);
                check("t6_rst_wr_addr", int'(wr_addr), 0);
                check("t6_rst_wr_data", int'(wr_data), 0);
            end
            if (c == 13 && rst_at >= 0) rst_n = 1'b1;
        end
    endtask

    task automatic send_frame();
        do_line(1'b0, 0, -1, -1, -1);
        do_line(1'b1, 8, -1, -1, -1);
        for (int v = 0; v < 4; v++) do_line(1'b1, 8, v, -1, -1);
        do_line(1'b1, 8, -1, -1, -1);
    endtask

    initial begin
        int bw, bd, be, b12, bs, late;
        rst_n  = 1'b0;
        enable = 1'b0;
        hsync  = 1'b1;
        vsync  = 1'b1;
        {r, g, b} = 12'h000;
        repeat (3) @(posedge pxclk);
        #1;
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_capturing", int'(capturing), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_frame_err", int'(frame_err), 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        do_line(1'b1, 0, -1, -1, -1);

        // Full frame at native resolution
        bw = n_wr; bd = n_done; be = n_ferr; b12 = n12; bs = ns;
        do_line(1'b0, 0, -1, -1, -1);
        do_line(1'b1, 8, -1, -1, -1);
        check("t1_capturing_mid", int'(capturing), 1);
        for (int v = 0; v < 4; v++) do_line(1'b1, 8, v, -1, -1);
        do_line(1'b1, 8, -1, -1, -1);
        check("t1_write_count", n_wr - bw, 32);
        for (int i = 0; i < 32; i++) begin
            check("t1_addr", la[bw + i], i);
            check("t1_data", ld[bw + i], pack332(src(i / 8, i % 8)));
        end
        check("t1_latency", lc[bw] - first_px_cyc, 2);
        check("t1_done_count", n_done - bd, 1);
        check("t1_done_after_last", done_cyc - lc[bw + 31], 1);
        check("t1_err_count", n_ferr - be, 0);
        check("t1_capturing_end", int'(capturing), 0);

        // Packing
        check("t2_rgb332_F85", ld[bw], 'hF1);
        check("t2_rgb12_count", n12 - b12, 32);
        check("t2_rgb12_F85", d12[b12], 'hF85);
        check("t2_rgb12_addr9", a12[b12 + 9], 9);
        check("t2_rgb12_data9", d12[b12 + 9], 'h22C);

        // Downscaled 4x2 instance
        check("t3_write_count", ns - bs, 8);
        for (int i = 0; i < 8; i++) begin
            check("t3_addr", as_[bs + i], i);
            check("t3_data", ds_[bs + i], pack332(src(2 * (i / 4), 2 * (i % 4))));
        end

        // Early vsync: row 2 still lands during the vsync line, then restart
        bw = n_wr; bd = n_done; be = n_ferr;
        do_line(1'b0, 0, -1, -1, -1);
        do_line(1'b1, 8, -1, -1, -1);
        do_line(1'b1, 8, 0, -1, -1);
        do_line(1'b1, 8, 1, -1, -1);
        send_frame();
        check("t4_err_count", n_ferr - be, 1);
        check("t4_write_count", n_wr - bw, 56);
        for (int i = 0; i < 56; i++)
            check("t4_addr", la[bw + i], (i < 24) ? i : i - 24);
        check("t4_restart_data", ld[bw + 24], 'hF1);
        check("t4_done_count", n_done - bd, 1);

        // Enable dropped mid-line 2
        bw = n_wr; bd = n_done; be = n_ferr;
        do_line(1'b0, 0, -1, -1, -1);
        do_line(1'b1, 8, -1, -1, -1);
        do_line(1'b1, 8, 0, -1, -1);
        do_line(1'b1, 8, 1, -1, -1);
        do_line(1'b1, 8, 2, 8, -1);
        check("t5_capturing", int'(capturing), 0);
        enable = 1'b1;
        do_line(1'b1, 8, 3, -1, -1);
        do_line(1'b1, 8, -1, -1, -1);
        check("t5_write_count", n_wr - bw, 19);
        check("t5_last_addr", la[bw + 18], 18);
        late = 0;
        for (int i = bw; i < n_wr; i++) if (lc[i] > drop_cyc) late++;
        check("t5_late_writes", late, 0);
        check("t5_done_count", n_done - bd, 0);
        check("t5_err_count", n_ferr - be, 0);
        bw = n_wr; bd = n_done;
        send_frame();
        check("t5_reenable_count", n_wr - bw, 32);
        check("t5_reenable_first", la[bw], 0);
        check("t5_reenable_done", n_done - bd, 1);

        // Asynchronous reset mid-frame
        bw = n_wr; bd = n_done;
        do_line(1'b0, 0, -1, -1, -1);
        do_line(1'b1, 8, -1, -1, -1);
        do_line(1'b1, 8, 0, -1, -1);
        do_line(1'b1, 8, 1, -1, 8);
        for (int v = 2; v < 4; v++) do_line(1'b1, 8, v, -1, -1);
        do_line(1'b1, 8, -1, -1, -1);
        check("t6_write_count", n_wr - bw, 10);
        check("t6_done_count", n_done - bd, 0);
        bw = n_wr; bd = n_done;
        send_frame();
        check("t6_after_count", n_wr - bw, 32);
        check("t6_after_first", la[bw], 0);
        check("t6_after_last", la[bw + 31], 31);
        check("t6_after_done", n_done - bd, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
